// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One 32-bit word per line; misses and all stores go to a req/ack memory port.
module dcache_ctrl #(
   parameter int LINES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  rw_flag,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_mask,
   output logic [31:0] read_data,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int INDEX_BITS = $clog2(LINES);
   localparam int TAG_W      = 30 - INDEX_BITS;

   localparam logic [2:0] RW_RD = 3'b001;
   localparam logic [2:0] RW_WR = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM_RD,
      S_MEM_WR,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [31:0]      read_data_q, read_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [3:0]       mem_wmask_q, mem_wmask_d;
   logic [LINES-1:0] valid_q, valid_d;

   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   logic [INDEX_BITS-1:0] idx_in;
   logic [TAG_W-1:0]      tag_in;
   logic                  hit_in;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_W-1:0]      fill_tag;
   logic [31:0]           upd_word;
   logic                  fill_en;
   logic                  upd_en;
   logic                  unused_addr;

   assign idx_in   = addr[INDEX_BITS+1:2];
   assign tag_in   = addr[31:INDEX_BITS+2];
   assign hit_in   = valid_q[idx_in] && (tag_mem[idx_in] == tag_in);
   // Fills target the address captured when the miss was accepted
   assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
   assign fill_tag = mem_addr_q[31:INDEX_BITS+2];

   assign unused_addr = ^addr[1:0];

   always_comb begin
      upd_word = data_mem[idx_in];
      for (int i = 0; i < 4; i++) begin
         if (write_mask[i]) begin
            upd_word[8*i +: 8] = write_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      read_data_d = read_data_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      valid_d     = valid_q;
      fill_en     = 1'b0;
      upd_en      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rw_flag == RW_RD) begin
               if (hit_in) begin
                  read_data_d = data_mem[idx_in];
                  state_d     = S_DONE;
               end else begin
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {addr[31:2], 2'b00};
                  state_d    = S_MEM_RD;
               end
            end else if (rw_flag == RW_WR) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_wdata_d = write_data;
               mem_wmask_d = write_mask;
               upd_en      = hit_in;
               state_d     = S_MEM_WR;
            end
         end
         S_MEM_RD: begin
            if (mem_ack) begin
               fill_en           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               read_data_d       = mem_rdata;
               mem_req_d         = 1'b0;
               state_d           = S_DONE;
            end
         end
         S_MEM_WR: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         read_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         read_data_q <= read_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         valid_q     <= valid_d;
      end
   end

   // Tag/data arrays need no reset; the valid bits gate every use
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mem_rdata;
      end else if (upd_en) begin
         data_mem[idx_in] <= upd_word;
      end
   end

   assign read_data = read_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a memory-level reference model.
// Read results are predicted from a flat memory image; a tag table predicts traffic.
module tb_dcache_ctrl;

   localparam logic [2:0] RD = 3'b001;
   localparam logic [2:0] WR = 3'b010;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  rw_flag;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [3:0]  write_mask;
   logic [31:0] read_data;
   logic        busy;
   logic        done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   dcache_ctrl #(.LINES(64)) dut (
      .clk(clk),
      .rst(rst),
      .rw_flag(rw_flag),
      .addr(addr),
      .write_data(write_data),
      .write_mask(write_mask),
      .read_data(read_data),
      .busy(busy),
      .done(done),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] mem_model [logic [29:0]];
   bit   [63:0] mvalid;
   logic [23:0] mtag [64];
   logic [31:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] nonreq();
      logic [2:0] v;
      do v = 3'($urandom_range(0, 7)); while (v == RD || v == WR);
      return v;
   endfunction

   task automatic do_req(input logic [2:0] rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input int dly, output logic [31:0] rd,
                         output bit missed);
      bit          is_wr;
      logic [29:0] wa;
      int          idx;
      bit          hit;
      bit          exp_mem;
      logic [31:0] memval;
      logic [31:0] base;
      int          cyc;
      int          nreq;
      int          dcyc;
      bit          got;
      is_wr   = (rw == WR);
      wa      = a[31:2];
      idx     = int'(a[7:2]);
      hit     = mvalid[idx] && (mtag[idx] == a[31:8]);
      exp_mem = is_wr || !hit;
      if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
      memval = mem_model[wa];
      rw_flag    = rw;
      addr       = a;
      write_data = wd;
      write_mask = wm;
      @(posedge clk);
      cyc  = 0;
      nreq = 0;
      dcyc = 0;
      got  = 0;
      while (!got && cyc < 24) begin
         @(negedge clk);
         cyc++;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (cyc == 1) begin
            chk("busy_after_accept", busy, 1'b1);
            addr       = $urandom;
            write_data = $urandom;
            write_mask = 4'($urandom);
         end
         if (done) begin
            got  = 1;
            dcyc = cyc;
            chk("req_low_at_done", mem_req, 1'b0);
         end else if (mem_req) begin
            nreq++;
            if (nreq == 1) begin
               chk("mem_addr", mem_addr, {a[31:2], 2'b00});
               chk("mem_we", mem_we, is_wr);
               if (is_wr) begin
                  chk("mem_wdata", mem_wdata, wd);
                  chk("mem_wmask", mem_wmask, wm);
               end
            end
            if (nreq == dly + 1) begin
               mem_ack = 1'b1;
               if (!is_wr) mem_rdata = memval;
            end
         end
      end
      chk("done_seen", got, 1'b1);
      chk("latency", dcyc, exp_mem ? dly + 2 : 1);
      chk("req_cycles", nreq, exp_mem ? dly + 1 : 0);
      if (is_wr) begin
         chk("rd_kept_on_write", read_data, last_rd);
         base = mem_model[wa];
         for (int i = 0; i < 4; i++)
            if (wm[i]) base[8*i +: 8] = wd[8*i +: 8];
         mem_model[wa] = base;
      end else begin
         chk("read_data", read_data, memval);
         last_rd = memval;
         mvalid[idx] = 1'b1;
         mtag[idx] = a[31:8];
      end
      rd = read_data;
      missed = (nreq > 0);
   endtask

   task automatic gap(input bit hold, input int extra);
      if (!hold) rw_flag = nonreq();
      repeat (hold ? 1 : 1 + extra) begin
         @(negedge clk);
         chk("gap_busy", busy, 1'b0);
         chk("gap_done", done, 1'b0);
         chk("gap_req", mem_req, 1'b0);
      end
   endtask

   task automatic reset_mid_miss();
      rw_flag = RD;
      addr = 32'h0000_0404;
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_up", mem_req, 1'b1);
      @(negedge clk);
      chk("rst_busy_up", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_req_drop", mem_req, 1'b0);
      chk("rst_busy_drop", busy, 1'b0);
      chk("rst_no_done", done, 1'b0);
      rw_flag = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("late_ack_busy", busy, 1'b0);
      chk("late_ack_done", done, 1'b0);
      chk("late_ack_req", mem_req, 1'b0);
      chk("rst_read_data", read_data, 32'h0);
      last_rd = '0;
      mvalid = '0;
   endtask

   initial begin
      logic [31:0] rd;
      bit          m;
      logic [2:0]  rwv;
      logic [2:0]  prev_rw;
      bit          hold;
      logic [31:0] a;
      logic [23:0] tagv;
      logic [5:0]  idxv;
      rst        = 1'b1;
      rw_flag    = 3'b000;
      addr       = '0;
      write_data = '0;
      write_mask = '0;
      mem_rdata  = '0;
      mem_ack    = 1'b0;
      mvalid     = '0;
      last_rd    = '0;
      prev_rw    = RD;
      hold       = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_rdata", read_data, 32'h0);
      chk("rst_maddr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_wmask", mem_wmask, 4'h0);
      rst = 1'b0;
      @(negedge clk);

      mem_model[30'h41] = 32'hDEAD_BEEF;
      mem_model[30'h81] = 32'h0BAD_F00D;

      do_req(RD, 32'h0000_0104, 0, 0, 2, rd, m);
      chk("t1_miss", m, 1'b1);
      chk("t1_data", rd, 32'hDEAD_BEEF);
      gap(0, 0);
      do_req(RD, 32'h0000_0104, 0, 0, 1, rd, m);
      chk("t1_hit", m, 1'b0);
      chk("t1_hit_data", rd, 32'hDEAD_BEEF);
      gap(0, 0);

      do_req(WR, 32'h0000_0104, 32'h1122_3344, 4'b0101, 1, rd, m);
      chk("t2_wr_mem", m, 1'b1);
      gap(0, 1);
      do_req(RD, 32'h0000_0104, 0, 0, 1, rd, m);
      chk("t2_hit", m, 1'b0);
      chk("t2_merge", rd, 32'hDE22_BE44);
      gap(0, 0);

      do_req(WR, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 0, rd, m);
      chk("t3_wr_mem", m, 1'b1);
      gap(0, 0);
      do_req(RD, 32'h0000_0200, 0, 0, 1, rd, m);
      chk("t3_no_alloc", m, 1'b1);
      chk("t3_data", rd, 32'hCAFE_F00D);
      gap(0, 0);

      do_req(RD, 32'h0000_0204, 0, 0, 1, rd, m);
      chk("t4_conflict_miss", m, 1'b1);
      chk("t4_data", rd, 32'h0BAD_F00D);
      gap(0, 0);
      do_req(RD, 32'h0000_0104, 0, 0, 0, rd, m);
      chk("t4_evicted", m, 1'b1);
      chk("t4_refill", rd, 32'hDE22_BE44);
      gap(0, 0);

      do_req(RD, 32'h0000_0304, 0, 0, 0, rd, m);
      chk("t5_miss", m, 1'b1);
      gap(1, 0);
      do_req(RD, 32'h0000_0304, 0, 0, 0, rd, m);
      chk("t5_reissue_hit", m, 1'b0);
      gap(0, 0);

      reset_mid_miss();
      do_req(RD, 32'h0000_0104, 0, 0, 1, rd, m);
      chk("t6_miss_after_rst", m, 1'b1);
      chk("t6_data", rd, 32'hDE22_BE44);
      gap(0, 0);

      for (int i = 0; i < 300; i++) begin
         if (hold) rwv = prev_rw;
         else rwv = ($urandom_range(0, 2) == 0) ? WR : RD;
         case ($urandom_range(0, 3))
            0: tagv = 24'h00_0000;
            1: tagv = 24'h00_0001;
            2: tagv = 24'h00_0002;
            default: tagv = 24'hFF_FFFF;
         endcase
         idxv = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
         a = {tagv, idxv, 2'($urandom)};
         do_req(rwv, a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, m);
         prev_rw = rwv;
         hold = (i < 299) && ($urandom_range(0, 3) == 0);
         gap(hold, hold ? 0 : $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Data-cache responder on the far end of mem_dcache_inf. It serves load/store requests from the mem_unit inside ex, and mem_unit is the initiator.
- Direct-mapped cache, one 32-bit word per line, write-through and no-write-allocate.
- Misses and all stores are forwarded to a word-wide main-memory port using a req/ack handshake.
- Returns busy/done/read_data to mem_unit.

Parameters:
- LINES, 64, number of cache lines; must be a power of two, 2..1024.
- INDEX_BITS, $clog2(LINES), index width. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rw_flag  input  3  request from mem_unit: 3'b001 read, 3'b010 write, every other value means no request.
- addr  input  32  byte address. addr[1:0] is ignored (word access).
- write_data  input  32  store data.
- write_mask  input  4  byte enables; bit i enables byte i ([8i+7:8i]).
- read_data  output  32  load result.
- busy  output  1  controller is not idle.
- done  output  1  one-cycle completion pulse.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  output  32  memory write data.
- mem_wmask  output  4  memory byte enables.
- mem_rdata  input  32  memory read data; valid when mem_ack = 1.
- mem_ack  input  1  completes the current memory request.

Behaviour:
- Reset: state = IDLE. busy, done, mem_req, mem_we = 0. read_data, mem_addr, mem_wdata = 0. mem_wmask = 0. All line valid bits are cleared.
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- Storage per line: valid bit, tag, 32-bit data word.
- Request acceptance:
  - A request is accepted only in IDLE, when rw_flag is 3'b001 or 3'b010.
  - addr, write_data and write_mask are registered at acceptance.
  - The requester holds rw_flag stable until it sees done.
  - rw_flag is ignored in every state except IDLE.
- busy = (state != IDLE), registered.
- States:
  - IDLE, read, hit (valid and tag match): read_data <= line data; next state DONE. Read-hit latency is 1 cycle (done in the cycle after acceptance).
  - IDLE, read, miss: mem_req=1, mem_we=0, mem_addr = word address; next state MEM_RD.
  - IDLE, write: mem_req=1, mem_we=1, mem_wdata=write_data, mem_wmask=write_mask; next state MEM_WR.
    - On a hit, the masked bytes of the line are updated in the same cycle.
    - On a miss, the cache is not modified.
  - MEM_RD: hold all mem_* outputs. On mem_ack:
    - fill the line (valid=1, tag, mem_rdata);
    - read_data <= mem_rdata;
    - mem_req <= 0;
    - next state DONE.
  - MEM_WR: hold all mem_* outputs. On mem_ack: mem_req <= 0; next state DONE.
  - DONE: done=1 for exactly this cycle; next state IDLE. A new request can be accepted in the following cycle at the earliest.
- read_data holds its value until the next completed read. A write does not change read_data.
- mem_ack is ignored while mem_req=0.
- mem_ack may arrive in the first cycle mem_req is high, which gives a minimum miss/store latency of 2 cycles to done.
- Writes with write_mask = 4'b0000 still issue the memory transaction. The line is left unchanged.
- Same-index store then load: the load sees the store data, whether through a hit update or a memory fill.
- Tag conflict on a read miss: the old line is overwritten. There is no dirty state, because the cache is write-through.
- Reset asserted mid-operation (MEM_RD or MEM_WR):
  - mem_req drops immediately and no done is issued;
  - all lines are invalidated;
  - a late mem_ack after reset is ignored.

Test Plan:
1. Read miss, then hit:
   - read addr 0x0000_0104; mem_ack 3 cycles later with rdata 0xDEADBEEF -> mem_req high 3 cycles, mem_addr=0x104, done with read_data=0xDEADBEEF.
   - Re-read 0x104 -> no mem_req, done 1 cycle after acceptance, read_data=0xDEADBEEF.
2. Write hit with mask:
   - line 0x104 holds 0xDEADBEEF; write 0x11223344 with mask 4'b0101 -> mem_we=1, mem_wmask=0101, done after ack.
   - Read 0x104 -> hit, read_data=0xDE22BE44.
3. Write miss (no-allocate): write 0x0000_0200 = 0xCAFEF00D on a cold line -> memory write issued. A following read of 0x200 misses (mem_req, mem_we=0).
4. Conflict eviction (LINES=64): fill 0x104, then read 0x204 (same index, different tag) -> miss and fill. Re-read 0x104 -> miss again.
5. Immediate ack and back-to-back:
   - mem_ack in the same cycle as the first mem_req -> done 2 cycles after acceptance.
   - rw_flag held through done and reissued -> exactly one transaction per request, with busy=0 for one cycle between requests.
6. Reset mid-miss: assert rst during MEM_RD -> mem_req=0 and busy=0 immediately, no done pulse. Re-read the previously cached 0x104 -> miss.
